signal_window_stats: RTL
========================

# signal_window_stats

Downstream consumer of the signal generator's sample stream. Accepts one signed sample per valid cycle and groups samples into fixed windows of 2^NB_WIN samples. For each window it reports maximum, minimum, peak-to-peak and mean, then raises a one-cycle result strobe. Windows run back-to-back for as long as the block is enabled.

## Interface

- NB_DATA, 8: sample width; two's-complement signed.
- NB_WIN, 4: log2 of window length N; N = 2^NB_WIN; must be ≥ 1.
- i_clock  in  1  single clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  high = windowing active; low = abort the window and idle.
- i_valid  in  1  i_data is a sample this cycle.
- i_data  in  NB_DATA  signed sample, the generator's output.
- o_max  out  NB_DATA  signed window maximum.
- o_min  out  NB_DATA  signed window minimum.
- o_pp  out  NB_DATA+1  unsigned, o_max − o_min.
- o_mean  out  NB_DATA  signed, window sum arithmetically shifted right by NB_WIN (floor toward −∞).
- o_valid  out  1  one-cycle strobe: new results are on the outputs.
- o_busy  out  1  high while a window is partially accumulated.

## Operation

- States: IDLE and ACC.
- IDLE → ACC when i_enable = 1. ACC → IDLE when i_enable = 0.
- Any i_enable = 0 cycle discards the partial window. o_valid is not raised for that window.
- A sample is accepted on an edge where state = ACC, i_enable = 1 and i_valid = 1. Samples presented in IDLE are ignored.
- Running registers per window:
  - cur_max, cur_min: NB_DATA signed.
  - sum: NB_DATA+NB_WIN signed; cannot overflow.
  - cnt: NB_WIN bits.
- First accepted sample of a window (cnt = 0): load cur_max = cur_min = sum = sample; cnt = 1.
- Later accepted samples: signed compare and update cur_max and cur_min; sum += sign-extended sample; cnt += 1.
- Window close: on the edge accepting the sample with cnt = N−1, the final values (including that last sample) are written to o_max, o_min, o_pp and o_mean.
  - o_valid = 1 for the following cycle only.
  - cnt wraps to 0, so the next accepted sample starts a fresh window with no gap.
- o_pp is computed at NB_DATA+1 bits from sign-extended operands. The result is always ≥ 0.
- Result outputs hold their last values until the next window closes. Neither abort nor IDLE clears them.
- o_busy = (state = ACC) and (cnt ≠ 0).
- Synchronous reset:
  - state = IDLE, cnt = 0.
  - All outputs 0: o_max, o_min, o_pp, o_mean, o_valid, o_busy.
  - Reset has priority over every other event, including a window close on the same edge; no o_valid follows.

## Timing

- Latency: the last sample of a window is presented in cycle t; o_valid and the results are visible in cycle t+1.
- Throughput: one sample per clock. Continuous i_valid gives an o_valid every N cycles.
- Gaps in i_valid do not change results. They only stretch the window.
- i_enable falling in the same cycle as a valid sample: the sample is not accepted and the window aborts.
- i_enable rising: samples are accepted from the next edge onward, because the first edge only moves IDLE → ACC.
- No backpressure: the block always accepts samples while in ACC.

## Structure

- Shared header signal_defs.vh holds:
  - the default NB_DATA, shared with signal_generator;
  - the state encodings ST_IDLE and ST_ACC.
- One sub-module, win_stats_acc, holds the running max/min/sum registers with load and update controls.
- The top level holds the state machine, cnt, and the output registers.
- Target size: roughly 150–250 lines of RTL.

## Test plan

All scenarios use NB_DATA = 8, NB_WIN = 2 (N = 4).

1. Reset: assert i_reset with i_valid toggling → all outputs 0, no o_valid.
2. Basic window: enable, then continuous samples 10, −5, 20, 3 → one cycle after the 4th sample: o_valid = 1 for exactly one cycle, o_max = 20, o_min = −5, o_pp = 25, o_mean = 7.
3. Gapped input: same four samples with one or two idle cycles between each → identical results. o_valid appears only after the 4th sample.
4. Extremes: −128, 127, −128, 127 → o_pp = 255, o_mean = −1 (sum −2 >>> 2). Then 1, 1, 1, 1 back-to-back → second o_valid exactly 4 cycles later with max = min = 1, pp = 0, mean = 1.
5. Abort: two samples, i_enable low for one cycle, then 4, 4, 8, 8 → no o_valid for the aborted window. Next result: max = 8, min = 4, pp = 4, mean = 6. Previous results stay held throughout.
6. Reset mid-window and on the close edge: reset after 3 samples, or coincident with the 4th → no o_valid, outputs 0. A new full window then reports correctly.

Source files
------------

// File: rtl/signal_window_stats_pkg.sv
// Shared definitions for the windowed sample statistics block.
package signal_window_stats_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_WIN_DEF  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_t;

endpackage

// File: rtl/win_stats_acc.sv
// Running max/min/sum of the current window. The o_nxt_* outputs show the
// values as they will be after the sample on i_data is taken in.
module win_stats_acc
  import signal_window_stats_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_WIN  = NB_WIN_DEF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_load,
  input  logic                      i_update,
  input  logic signed [NB_DATA-1:0] i_data,
  output logic signed [NB_DATA-1:0] o_nxt_max,
  output logic signed [NB_DATA-1:0] o_nxt_min,
  output logic signed [NB_DATA-1:0] o_nxt_mean
);

  localparam int NB_SUM = NB_DATA + NB_WIN;

  logic signed [NB_DATA-1:0] r_max;
  logic signed [NB_DATA-1:0] r_min;
  logic signed [NB_SUM-1:0]  r_sum;
  logic signed [NB_SUM-1:0]  w_nxt_sum;
  logic signed [NB_SUM-1:0]  w_data_ext;

  assign w_data_ext = {{NB_WIN{i_data[NB_DATA-1]}}, i_data};

  always_comb begin
    o_nxt_max = r_max;
    o_nxt_min = r_min;
    w_nxt_sum = r_sum;
    if (i_load) begin
      o_nxt_max = i_data;
      o_nxt_min = i_data;
      w_nxt_sum = w_data_ext;
    end else begin
      if (i_data > r_max) o_nxt_max = i_data;
      if (i_data < r_min) o_nxt_min = i_data;
      w_nxt_sum = r_sum + w_data_ext;
    end
  end

  // Dropping the low NB_WIN bits of a two's-complement sum is an arithmetic
  // shift, i.e. floor toward minus infinity.
  assign o_nxt_mean = w_nxt_sum[NB_SUM-1:NB_WIN];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_max <= '0;
      r_min <= '0;
      r_sum <= '0;
    end else if (i_update) begin
      r_max <= o_nxt_max;
      r_min <= o_nxt_min;
      r_sum <= w_nxt_sum;
    end
  end

endmodule

// File: rtl/signal_window_stats.sv
// Groups a signed sample stream into back-to-back windows of 2^NB_WIN samples
// and reports max, min, peak-to-peak and mean of each completed window.
module signal_window_stats
  import signal_window_stats_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_WIN  = NB_WIN_DEF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_data,
  output logic signed [NB_DATA-1:0] o_max,
  output logic signed [NB_DATA-1:0] o_min,
  output logic        [NB_DATA:0]   o_pp,
  output logic signed [NB_DATA-1:0] o_mean,
  output logic                      o_valid,
  output logic                      o_busy
);

  localparam logic [NB_WIN-1:0] CNT_LAST = '1;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [NB_WIN-1:0]         r_cnt;
  logic signed [NB_DATA-1:0] r_max;
  logic signed [NB_DATA-1:0] r_min;
  logic [NB_DATA:0]          r_pp;
  logic signed [NB_DATA-1:0] r_mean;
  logic                      r_valid;

  logic                      w_accept;
  logic                      w_close;
  logic signed [NB_DATA-1:0] w_nxt_max;
  logic signed [NB_DATA-1:0] w_nxt_min;
  logic signed [NB_DATA-1:0] w_nxt_mean;
  logic [NB_DATA:0]          w_pp;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_enable)  w_state_next = ST_ACC;
      ST_ACC:  if (!i_enable) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_accept = (r_state == ST_ACC) && i_enable && i_valid;
  assign w_close  = w_accept && (r_cnt == CNT_LAST);

  win_stats_acc #(
    .NB_DATA (NB_DATA),
    .NB_WIN  (NB_WIN)
  ) u_acc (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_load     (r_cnt == '0),
    .i_update   (w_accept),
    .i_data     (i_data),
    .o_nxt_max  (w_nxt_max),
    .o_nxt_min  (w_nxt_min),
    .o_nxt_mean (w_nxt_mean)
  );

  // Both operands sign-extended by one bit so the difference never wraps.
  assign w_pp = {w_nxt_max[NB_DATA-1], w_nxt_max} - {w_nxt_min[NB_DATA-1], w_nxt_min};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_max   <= '0;
      r_min   <= '0;
      r_pp    <= '0;
      r_mean  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_close;
      // Dropping enable throws the partial window away.
      if (!i_enable) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_close) begin
        r_max  <= w_nxt_max;
        r_min  <= w_nxt_min;
        r_pp   <= w_pp;
        r_mean <= w_nxt_mean;
      end
    end
  end

  assign o_max   = r_max;
  assign o_min   = r_min;
  assign o_pp    = r_pp;
  assign o_mean  = r_mean;
  assign o_valid = r_valid;
  assign o_busy  = (r_state == ST_ACC) && (r_cnt != '0);

endmodule
